conv_window_streamer: RTL and testbench

Streaming input stage that sits directly upstream of the conv engine. It accepts ifmap pixels one per beat in raster order and keeps KERNEL_HEIGHT-1 rows in line buffers. It emits one complete KERNEL_HEIGHT x KERNEL_WIDTH window for each conv output position, honouring H_STRIDE and V_STRIDE. Both sides use valid/ready handshakes, so DRAM/file loaders upstream and the MAC array downstream can stall independently.

---
 rtl/conv_window_streamer.sv | 123 ++++++++++++
 tb/tb_conv_window_streamer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_streamer.sv
// conv_window_streamer: raster pixel stream in, strided KERNEL_HEIGHT x KERNEL_WIDTH windows out.
// Line buffers hold the previous rows; a one-deep output register decouples the consumer.
module conv_window_streamer #(
    parameter int IFMAP_HEIGHT  = 512,
    parameter int IFMAP_WIDTH   = 512,
    parameter int KERNEL_HEIGHT = 3,
    parameter int KERNEL_WIDTH  = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int H_STRIDE      = 1,
    parameter int V_STRIDE      = 1
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               en,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [DATA_WIDTH-1:0]                              in_data,
    output logic                                               win_valid,
    input  logic                                               win_ready,
    output logic [KERNEL_HEIGHT*KERNEL_WIDTH*DATA_WIDTH-1:0]   win_data,
    output logic                                               frame_done
);
    localparam int KH  = KERNEL_HEIGHT;
    localparam int KW  = KERNEL_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam int WW  = KH * KW * DW;
    localparam int CW  = IFMAP_WIDTH > 1 ? $clog2(IFMAP_WIDTH) : 1;
    localparam int RW  = IFMAP_HEIGHT > 1 ? $clog2(IFMAP_HEIGHT) : 1;
    localparam int HPW = H_STRIDE > 1 ? $clog2(H_STRIDE) : 1;
    localparam int VPW = V_STRIDE > 1 ? $clog2(V_STRIDE) : 1;
    localparam int LBR = KH > 1 ? KH - 1 : 1;
    localparam int LAST_ROW = KH - 1 + ((IFMAP_HEIGHT - KH) / V_STRIDE) * V_STRIDE;
    localparam int LAST_COL = KW - 1 + ((IFMAP_WIDTH - KW) / H_STRIDE) * H_STRIDE;
    localparam logic [CW-1:0]  COL_MAX = CW'(IFMAP_WIDTH - 1);
    localparam logic [CW-1:0]  COL_K   = CW'(KW - 1);
    localparam logic [CW-1:0]  COL_END = CW'(LAST_COL);
    localparam logic [RW-1:0]  ROW_MAX = RW'(IFMAP_HEIGHT - 1);
    localparam logic [RW-1:0]  ROW_K   = RW'(KH - 1);
    localparam logic [RW-1:0]  ROW_END = RW'(LAST_ROW);
    localparam logic [HPW-1:0] H_MAX   = HPW'(H_STRIDE - 1);
    localparam logic [VPW-1:0] V_MAX   = VPW'(V_STRIDE - 1);

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [HPW-1:0] hph_q, hph_d;
    logic [VPW-1:0] vph_q, vph_d;
    logic [WW-1:0]  sw_q, sw_d, win_data_q, win_data_d;
    logic           win_valid_q, win_valid_d, win_last_q, win_last_d, frame_done_q, frame_done_d;
    logic [DW-1:0]  lb_q [LBR][IFMAP_WIDTH];
    logic [DW-1:0]  col_vec [KH];
    logic           acc, hit, emit, col_wrap, row_wrap;

    assign in_ready   = en && !reset && (!win_valid_q || win_ready);
    assign acc        = in_valid && in_ready;
    assign col_wrap   = col_q == COL_MAX;
    assign row_wrap   = row_q == ROW_MAX;
    // Stride phases are zero exactly on the rows/columns that produce a window.
    assign hit        = row_q >= ROW_K && col_q >= COL_K && hph_q == '0 && vph_q == '0;
    assign emit       = acc && hit;
    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign frame_done = frame_done_q;

    always_comb begin
        col_vec[KH-1] = in_data;
        for (int i = 0; i < KH - 1; i++) col_vec[i] = lb_q[KH-2-i][col_q];
        sw_d = sw_q;
        if (acc) begin
            sw_d = sw_q >> DW;
            for (int r = 0; r < KH; r++) sw_d[(r*KW+KW-1)*DW +: DW] = col_vec[r];
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        hph_d = hph_q;
        vph_d = vph_q;
        if (acc) begin
            col_d = col_wrap ? '0 : col_q + 1'b1;
            hph_d = (col_wrap || col_q < COL_K || hph_q == H_MAX) ? '0 : hph_q + 1'b1;
            if (col_wrap) begin
                row_d = row_wrap ? '0 : row_q + 1'b1;
                vph_d = (row_wrap || row_q < ROW_K || vph_q == V_MAX) ? '0 : vph_q + 1'b1;
            end
        end
        win_valid_d  = emit ? 1'b1 : win_valid_q && !win_ready;
        win_data_d   = emit ? sw_d : win_data_q;
        win_last_d   = emit ? (row_q == ROW_END && col_q == COL_END) : win_last_q;
        frame_done_d = win_valid_q && win_ready && win_last_q;
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            for (int j = LBR - 1; j > 0; j--) lb_q[j][col_q] <= lb_q[j-1][col_q];
            lb_q[0][col_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            hph_q        <= '0;
            vph_q        <= '0;
            sw_q         <= '0;
            win_data_q   <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hph_q        <= hph_d;
            vph_q        <= vph_d;
            sw_q         <= sw_d;
            win_data_q   <= win_data_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_conv_window_streamer.sv
// tb_conv_window_streamer: scoreboard bench over three streamer configurations sharing one stimulus driver.
module tb_conv_window_streamer;
    logic clk = 1'b0;
    logic reset, en, in_valid, win_ready;
    logic [7:0] in_data;
    logic [1:0] sel;
    logic [2:0] iv, rdy, wv, fd;
    logic [2:0][71:0] wd;
    logic [47:0] wd_c;
    logic [71:0] exp_q[$];
    logic [71:0] cap[$];
    logic [71:0] e;
    int checks = 0, errors = 0, fd_cnt = 0;
    bit stop;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_iv
        assign iv[k] = in_valid && (sel == 2'(k));
    end
    assign wd[2] = {24'b0, wd_c};

    conv_window_streamer #(.IFMAP_HEIGHT(5), .IFMAP_WIDTH(5), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(3),
        .DATA_WIDTH(8), .H_STRIDE(1), .V_STRIDE(1)) u_a (
        .clk(clk), .reset(reset), .en(en), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(in_data),
        .win_valid(wv[0]), .win_ready(win_ready), .win_data(wd[0]), .frame_done(fd[0]));
    conv_window_streamer #(.IFMAP_HEIGHT(5), .IFMAP_WIDTH(5), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(3),
        .DATA_WIDTH(8), .H_STRIDE(2), .V_STRIDE(2)) u_b (
        .clk(clk), .reset(reset), .en(en), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(in_data),
        .win_valid(wv[1]), .win_ready(win_ready), .win_data(wd[1]), .frame_done(fd[1]));
    conv_window_streamer #(.IFMAP_HEIGHT(6), .IFMAP_WIDTH(7), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(2),
        .DATA_WIDTH(8), .H_STRIDE(1), .V_STRIDE(1)) u_c (
        .clk(clk), .reset(reset), .en(en), .in_valid(iv[2]), .in_ready(rdy[2]), .in_data(in_data),
        .win_valid(wv[2]), .win_ready(win_ready), .win_data(wd_c), .frame_done(fd[2]));

    function automatic logic [71:0] win_of(int r0, int c0, int kh, int kw, int w, int base);
        logic [71:0] v = '0;
        for (int i = 0; i < kh; i++)
            for (int j = 0; j < kw; j++) v[(i*kw+j)*8 +: 8] = 8'(base + (r0 + i) * w + c0 + j);
        return v;
    endfunction

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic send_frame(input int k, input int h, input int w, input int kh, input int kw,
                              input int hs, input int vs, input int base, input int npix,
                              input bit bub, input bit lat);
        for (int p = 0; p < npix; p++) begin
            int r, c, t;
            bit done, em;
            r = (p / w) % h;
            c = p % w;
            t = 0;
            done = 0;
            em = r >= kh - 1 && c >= kw - 1 && (r - kh + 1) % vs == 0 && (c - kw + 1) % hs == 0;
            in_data = 8'(base + r * w + c);
            while (!done) begin
                in_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                if (in_valid && rdy[k]) begin
                    done = 1;
                    if (em) exp_q.push_back(win_of(r - kh + 1, c - kw + 1, kh, kw, w, base));
                end else if (++t > 300) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout inst=%0d pixel=%0d got=stalled expected=accepted", k, p);
                    in_valid = 0;
                    return;
                end
                @(posedge clk);
                #1;
                if (done && lat) chk($sformatf("latency_p%0d", p), 72'(wv[k]), 72'(em));
            end
            in_valid = 0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || wv != 0) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d pending expected=0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                if (wv[k] && win_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL win_extra inst=%0d got=%h expected=none", k, wd[k]);
                    end else begin
                        e = exp_q.pop_front();
                        if (wd[k] !== e) begin
                            errors++;
                            $display("FAIL win_data inst=%0d got=%h expected=%h", k, wd[k], e);
                        end
                    end
                    cap.push_back(wd[k]);
                end
                if (fd[k]) fd_cnt++;
            end
        end
    end

    localparam logic [71:0] W_FIRST = 72'h0c0b0a_070605_020100;
    localparam logic [71:0] W_LAST  = 72'h181716_131211_0e0d0c;
    localparam logic [71:0] W_S2_1  = 72'h0e0d0c_090807_040302;
    localparam logic [71:0] W_F2_0  = 72'h706f6e_6b6a69_666564;

    initial begin
        reset = 1; en = 1; in_valid = 0; in_data = 0; win_ready = 1; sel = 0; stop = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 72'(rdy), 72'd0);
        chk("reset_win_valid", 72'(wv), 72'd0);
        chk("reset_win_data", wd[0] | wd[1] | wd[2], 72'd0);
        chk("reset_frame_done", 72'(fd), 72'd0);
        reset = 0;

        cap.delete(); fd_cnt = 0; sel = 0;
        send_frame(0, 5, 5, 3, 3, 1, 1, 0, 25, 0, 1);
        drain();
        chk("s1_count", 72'(cap.size()), 72'd9);
        chk("s1_first", cap[0], W_FIRST);
        chk("s1_last", cap[8], W_LAST);
        chk("s1_frame_done", 72'(fd_cnt), 72'd1);

        cap.delete(); fd_cnt = 0; sel = 1;
        send_frame(1, 5, 5, 3, 3, 2, 2, 0, 25, 0, 1);
        drain();
        chk("s2_count", 72'(cap.size()), 72'd4);
        chk("s2_second", cap[1], W_S2_1);
        chk("s2_frame_done", 72'(fd_cnt), 72'd1);

        cap.delete(); fd_cnt = 0; sel = 0; win_ready = 0;
        fork
            send_frame(0, 5, 5, 3, 3, 1, 1, 0, 25, 0, 0);
            begin
                int t = 0;
                @(negedge clk);
                while (!wv[0] && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_first_valid", 72'(wv[0]), 72'd1);
                for (int i = 0; i < 5; i++) begin
                    chk($sformatf("bp_hold_data_%0d", i), wd[0], W_FIRST);
                    chk($sformatf("bp_hold_ready_%0d", i), 72'(rdy[0]), 72'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                win_ready = 1;
            end
        join
        drain();
        chk("bp_count", 72'(cap.size()), 72'd9);
        chk("bp_first", cap[0], W_FIRST);
        chk("bp_last", cap[8], W_LAST);
        chk("bp_frame_done", 72'(fd_cnt), 72'd1);

        cap.delete(); fd_cnt = 0; sel = 2; stop = 0;
        fork
            begin
                send_frame(2, 6, 7, 3, 2, 1, 1, 0, 42, 1, 0);
                stop = 1;
            end
            begin
                while (!stop) begin
                    win_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                win_ready = 1;
            end
        join
        drain();
        chk("rnd_count", 72'(cap.size()), 72'd24);
        chk("rnd_frame_done", 72'(fd_cnt), 72'd1);

        cap.delete(); fd_cnt = 0; sel = 0; win_ready = 1;
        send_frame(0, 5, 5, 3, 3, 1, 1, 0, 9, 0, 1);
        reset = 1;
        @(posedge clk);
        #1;
        chk("mid_reset_in_ready", 72'(rdy[0]), 72'd0);
        chk("mid_reset_win_valid", 72'(wv[0]), 72'd0);
        chk("mid_reset_win_data", wd[0], 72'd0);
        chk("mid_reset_frame_done", 72'(fd[0]), 72'd0);
        reset = 0;
        en = 0;
        #1;
        chk("en_low_in_ready", 72'(rdy[0]), 72'd0);
        en = 1;
        @(posedge clk);
        #1;
        send_frame(0, 5, 5, 3, 3, 1, 1, 0, 25, 0, 1);
        drain();
        chk("rst_count", 72'(cap.size()), 72'd9);
        chk("rst_first", cap[0], W_FIRST);
        chk("rst_last", cap[8], W_LAST);
        chk("rst_frame_done", 72'(fd_cnt), 72'd1);

        cap.delete(); fd_cnt = 0;
        send_frame(0, 5, 5, 3, 3, 1, 1, 0, 25, 0, 1);
        send_frame(0, 5, 5, 3, 3, 1, 1, 100, 25, 0, 1);
        drain();
        chk("b2b_count", 72'(cap.size()), 72'd18);
        chk("b2b_f2_first", cap[9], W_F2_0);
        chk("b2b_frame_done", 72'(fd_cnt), 72'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
